// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage controller.
// The MEM_TIMEOUT_EN build option lives in mem_stage_ctrl.sv.
package mem_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    wb_ctrl_t          ctrl;
    logic [DW-1:0]     read_data;
    logic [DW-1:0]     alu_result;
    logic [RW-1:0]     wbreg;
  } mem_wb_t;

  // Control fields loaded into MEM/WB when the stage inserts a bubble.
  localparam wb_ctrl_t WB_CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |(addr_lo & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and memory (slave).
interface mem_stage_ctrl_if #(
  parameter int unsigned AW = mem_pkg::AW_DEF
) ();

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: bubble clears the control fields and holds the data fields.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_bubble,
  input  logic          i_load_done,
  input  wb_ctrl_t      i_ctrl,
  input  logic [DW-1:0] i_alu_result,
  input  logic [RW-1:0] i_wbreg,
  input  logic [DW-1:0] i_rdata,
  output mem_wb_t       o_q
);

  mem_wb_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q.ctrl <= WB_CTRL_BUBBLE;
    end else begin
      r_q.ctrl       <= i_ctrl;
      r_q.alu_result <= i_alu_result;
      r_q.wbreg      <= i_wbreg;
      if (i_load_done) begin
        r_q.read_data <= i_rdata;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage engine: data-memory handshake FSM, stall generation, PC select, MEM/WB load.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog and the err_timeout port.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read_ex_mem,
  input  logic                mem_write_ex_mem,
  input  logic                mem_to_reg_ex_mem,
  input  logic                reg_write_ex_mem,
  input  logic                branch_ex_mem,
  input  logic                zero_ex_mem,
  input  logic                jump_ex_mem,
  input  logic [31:0]         alu_result_ex_mem,
  input  logic [31:0]         rt_data_ex_mem,
  input  logic [4:0]          writebackreg_ex_mem,
  mem_stage_ctrl_if.master    dmem,
  output logic                stall_mem,
  output logic                pcsrc_branch,
  output logic                pcsrc_jump,
  output logic                err_misaligned,
`ifdef MEM_TIMEOUT_EN
  output logic                err_timeout,
`endif
  output logic                reg_write_mem_wb,
  output logic                mem_to_reg_mem_wb,
  output logic [31:0]         read_data_mem_wb,
  output logic [31:0]         alu_result_mem_wb,
  output logic [4:0]          writebackreg_mem_wb
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_pre;
  logic [ST_W-1:0] w_state_nxt;
  logic            w_mem_op;
  logic            w_is_store;
  logic            w_misaligned;
  logic            w_req;
  logic            w_done;
  logic            w_load_done;
  logic            w_stall_raw;
  logic            w_abort;
  logic            r_err_misaligned;
  mem_wb_t         w_mem_wb;

  assign w_mem_op     = mem_read_ex_mem | mem_write_ex_mem;
  assign w_is_store   = mem_write_ex_mem;
  assign w_misaligned = w_mem_op & is_misaligned(alu_result_ex_mem[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake sequencing; a store retires on gnt, a load on rvalid.
  always_comb begin
    w_state_pre = r_state;
    w_req       = 1'b0;
    w_done      = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op && !w_misaligned) begin
          w_req = 1'b1;
          if (dmem.dmem_gnt) begin
            if (w_is_store) begin
              w_done = 1'b1;
            end else begin
              w_state_pre = ST_RESP;
            end
          end else begin
            w_state_pre = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (dmem.dmem_gnt) begin
          if (w_is_store) begin
            w_done      = 1'b1;
            w_state_pre = ST_IDLE;
          end else begin
            w_state_pre = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (dmem.dmem_rvalid) begin
          w_done      = 1'b1;
          w_load_done = 1'b1;
          w_state_pre = ST_IDLE;
        end
      end
      default: w_state_pre = ST_IDLE;
    endcase
  end

  assign w_stall_raw = w_mem_op & ~w_done & ~w_misaligned;
  assign w_state_nxt = w_abort ? ST_IDLE : w_state_pre;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err_timeout;

  assign w_abort = w_stall_raw & (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive stalled cycles of the current access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_abort;
      if (w_stall_raw && !w_abort) begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_misaligned <= 1'b0;
    end else begin
      r_err_misaligned <= w_misaligned;
    end
  end

  // Request is gated by reset so nothing leaves the stage while it is held.
  assign dmem.dmem_req   = w_req & rst_n;
  assign dmem.dmem_we    = w_is_store;
  assign dmem.dmem_addr  = AW'(alu_result_ex_mem);
  assign dmem.dmem_wdata = rt_data_ex_mem;

  assign stall_mem      = w_stall_raw & ~w_abort & rst_n;
  assign pcsrc_branch   = branch_ex_mem & zero_ex_mem;
  assign pcsrc_jump     = jump_ex_mem;
  assign err_misaligned = r_err_misaligned;

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_bubble     (w_stall_raw | w_misaligned),
    .i_load_done  (w_load_done),
    .i_ctrl       ('{reg_write: reg_write_ex_mem, mem_to_reg: mem_to_reg_ex_mem}),
    .i_alu_result (alu_result_ex_mem),
    .i_wbreg      (writebackreg_ex_mem),
    .i_rdata      (dmem.dmem_rdata),
    .o_q          (w_mem_wb)
  );

  assign reg_write_mem_wb    = w_mem_wb.ctrl.reg_write;
  assign mem_to_reg_mem_wb   = w_mem_wb.ctrl.mem_to_reg;
  assign read_data_mem_wb    = w_mem_wb.read_data;
  assign alu_result_mem_wb   = w_mem_wb.alu_result;
  assign writebackreg_mem_wb = w_mem_wb.wbreg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed table-driven bench for mem_stage_ctrl, plus reset-mid-access and timeout sequences.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read_ex_mem, mem_write_ex_mem, mem_to_reg_ex_mem, reg_write_ex_mem;
  logic        branch_ex_mem, zero_ex_mem, jump_ex_mem;
  logic [31:0] alu_result_ex_mem, rt_data_ex_mem;
  logic [4:0]  writebackreg_ex_mem;
  logic        stall_mem, pcsrc_branch, pcsrc_jump, err_misaligned;
  logic        reg_write_mem_wb, mem_to_reg_mem_wb;
  logic [31:0] read_data_mem_wb, alu_result_mem_wb;
  logic [4:0]  writebackreg_mem_wb;
`ifdef MEM_TIMEOUT_EN
  logic        err_timeout;
`endif

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl_if #(.AW(32)) dmem_if ();

  mem_stage_ctrl #(
    .AW(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_read_ex_mem     (mem_read_ex_mem),
    .mem_write_ex_mem    (mem_write_ex_mem),
    .mem_to_reg_ex_mem   (mem_to_reg_ex_mem),
    .reg_write_ex_mem    (reg_write_ex_mem),
    .branch_ex_mem       (branch_ex_mem),
    .zero_ex_mem         (zero_ex_mem),
    .jump_ex_mem         (jump_ex_mem),
    .alu_result_ex_mem   (alu_result_ex_mem),
    .rt_data_ex_mem      (rt_data_ex_mem),
    .writebackreg_ex_mem (writebackreg_ex_mem),
    .dmem                (dmem_if),
    .stall_mem           (stall_mem),
    .pcsrc_branch        (pcsrc_branch),
    .pcsrc_jump          (pcsrc_jump),
    .err_misaligned      (err_misaligned),
`ifdef MEM_TIMEOUT_EN
    .err_timeout         (err_timeout),
`endif
    .reg_write_mem_wb    (reg_write_mem_wb),
    .mem_to_reg_mem_wb   (mem_to_reg_mem_wb),
    .read_data_mem_wb    (read_data_mem_wb),
    .alu_result_mem_wb   (alu_result_mem_wb),
    .writebackreg_mem_wb (writebackreg_mem_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs, expected combinational outputs, expected MEM/WB after the edge.
  typedef struct {
    logic        rd, wr, m2r, rw, br, z, j;
    logic [31:0] alu, rt;
    logic [4:0]  wb;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall, e_pcb, e_pcj;
    logic        e_rw, e_m2r;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wb;
    logic        e_err;
  } vec_t;

  vec_t tbl[12];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    mem_read_ex_mem      = x.rd;
    mem_write_ex_mem     = x.wr;
    mem_to_reg_ex_mem    = x.m2r;
    reg_write_ex_mem     = x.rw;
    branch_ex_mem        = x.br;
    zero_ex_mem          = x.z;
    jump_ex_mem          = x.j;
    alu_result_ex_mem    = x.alu;
    rt_data_ex_mem       = x.rt;
    writebackreg_ex_mem  = x.wb;
    dmem_if.dmem_gnt     = x.gnt;
    dmem_if.dmem_rvalid  = x.rv;
    dmem_if.dmem_rdata   = x.rdata;
  endtask

  task automatic check_regs(input vec_t x, input string tag);
    chk({tag, ".rw_wb"},  32'(reg_write_mem_wb),    32'(x.e_rw));
    chk({tag, ".m2r_wb"}, 32'(mem_to_reg_mem_wb),   32'(x.e_m2r));
    chk({tag, ".rd_wb"},  read_data_mem_wb,         x.e_rd);
    chk({tag, ".alu_wb"}, alu_result_mem_wb,        x.e_alu);
    chk({tag, ".dst_wb"}, 32'(writebackreg_mem_wb), 32'(x.e_wb));
    chk({tag, ".err_mis"}, 32'(err_misaligned),     32'(x.e_err));
  endtask

  task automatic run_vec(input vec_t x, input string tag);
    @(negedge clk);
    drive(x);
    #1;
    chk({tag, ".req"},   32'(dmem_if.dmem_req), 32'(x.e_req));
    chk({tag, ".we"},    32'(dmem_if.dmem_we),  32'(x.e_we));
    chk({tag, ".stall"}, 32'(stall_mem),        32'(x.e_stall));
    chk({tag, ".pcb"},   32'(pcsrc_branch),     32'(x.e_pcb));
    chk({tag, ".pcj"},   32'(pcsrc_jump),       32'(x.e_pcj));
    if (x.e_req) begin
      chk({tag, ".addr"}, dmem_if.dmem_addr, x.alu);
      if (x.e_we) chk({tag, ".wdata"}, dmem_if.dmem_wdata, x.rt);
    end
    @(posedge clk);
    #1;
    check_regs(x, tag);
  endtask

  initial begin
    // rd wr m2r rw br z j | alu rt wb | gnt rv rdata | req we stall pcb pcj | rw m2r rd alu wb err
    tbl[0]  = '{0,0,0,1,0,0,0, 32'h100, 32'h0, 5'd3, 0,0,32'h0,
                0,0,0,0,0, 1,0,32'h0,        32'h100, 5'd3, 0};
    tbl[1]  = '{0,1,0,0,0,0,0, 32'h10, 32'hDEADBEEF, 5'd0, 1,0,32'h0,
                1,1,0,0,0, 0,0,32'h0,        32'h10, 5'd0, 0};
    tbl[2]  = '{1,0,1,1,0,0,0, 32'h20, 32'h0, 5'd5, 0,0,32'h0,
                1,0,1,0,0, 0,0,32'h0,        32'h10, 5'd0, 0};
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = '{1,0,1,1,0,0,0, 32'h20, 32'h0, 5'd5, 1,0,32'h0,
                1,0,1,0,0, 0,0,32'h0,        32'h10, 5'd0, 0};
    tbl[6]  = '{1,0,1,1,0,0,0, 32'h20, 32'h0, 5'd5, 0,0,32'h0,
                0,0,1,0,0, 0,0,32'h0,        32'h10, 5'd0, 0};
    tbl[7]  = '{1,0,1,1,0,0,0, 32'h20, 32'h0, 5'd5, 0,1,32'h12345678,
                0,0,0,0,0, 1,1,32'h12345678, 32'h20, 5'd5, 0};
    tbl[8]  = '{1,0,1,1,0,0,0, 32'h22, 32'h0, 5'd6, 1,0,32'h0,
                0,0,0,0,0, 0,0,32'h12345678, 32'h20, 5'd5, 1};
    tbl[9]  = '{0,0,0,0,1,1,0, 32'h0, 32'h0, 5'd0, 1,1,32'hFFFFFFFF,
                0,0,0,1,0, 0,0,32'h12345678, 32'h0, 5'd0, 0};
    tbl[10] = '{0,0,0,1,1,0,1, 32'h44, 32'h0, 5'd31, 0,0,32'h0,
                0,0,0,0,1, 1,0,32'h12345678, 32'h44, 5'd31, 0};
    tbl[11] = '{1,1,0,0,0,0,0, 32'h30, 32'hA5A5A5A5, 5'd0, 1,0,32'h0,
                1,1,0,0,0, 0,0,32'h12345678, 32'h30, 5'd0, 0};

    rst_n = 1'b0;
    v = '{0,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0, 0,0,32'h0,
          0,0,0,0,0, 0,0,32'h0, 32'h0, 5'd0, 0};
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    check_regs(v, "reset");
    chk("reset.stall", 32'(stall_mem), 32'h0);
    chk("reset.req", 32'(dmem_if.dmem_req), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    // Reset while waiting for rvalid, then stale rvalid, then a clean load.
    v = '{1,0,1,1,0,0,0, 32'h40, 32'h0, 5'd7, 1,0,32'h0,
          1,0,1,0,0, 0,0,32'h12345678, 32'h30, 5'd0, 0};
    run_vec(v, "r1");
    @(negedge clk);
    dmem_if.dmem_gnt = 1'b0;
    #1;
    chk("r_resp.stall", 32'(stall_mem), 32'h1);
    chk("r_resp.req", 32'(dmem_if.dmem_req), 32'h0);
    rst_n = 1'b0;
    #1;
    v = '{0,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0, 0,0,32'h0,
          0,0,0,0,0, 0,0,32'h0, 32'h0, 5'd0, 0};
    check_regs(v, "r_async");
    chk("r_async.stall", 32'(stall_mem), 32'h0);
    chk("r_async.req", 32'(dmem_if.dmem_req), 32'h0);
    v = '{0,0,0,0,0,0,0, 32'h50, 32'h0, 5'd0, 0,1,32'h00000BAD,
          0,0,0,0,0, 0,0,32'h0, 32'h50, 5'd0, 0};
    drive(v);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(v, "r2");
    v = '{1,0,1,1,0,0,0, 32'h60, 32'h0, 5'd9, 1,0,32'h0,
          1,0,1,0,0, 0,0,32'h0, 32'h50, 5'd0, 0};
    run_vec(v, "r3");
    v = '{1,0,1,1,0,0,0, 32'h60, 32'h0, 5'd9, 0,1,32'hCAFEF00D,
          0,0,0,0,0, 1,1,32'hCAFEF00D, 32'h60, 5'd9, 0};
    run_vec(v, "r4");

`ifdef MEM_TIMEOUT_EN
    // gnt never arrives: seven stalled cycles, abort on the eighth.
    v = '{1,0,1,1,0,0,0, 32'h80, 32'h0, 5'd2, 0,0,32'h0,
          1,0,1,0,0, 0,0,32'hCAFEF00D, 32'h60, 5'd9, 0};
    for (int k = 1; k <= 7; k++) begin
      run_vec(v, $sformatf("t%0d", k));
      chk($sformatf("t%0d.err_to", k), 32'(err_timeout), 32'h0);
    end
    v.e_stall = 1'b0;
    run_vec(v, "t8");
    chk("t8.err_to", 32'(err_timeout), 32'h1);
    v = '{0,0,0,1,0,0,0, 32'h90, 32'h0, 5'd4, 0,1,32'h00000BAD,
          0,0,0,0,0, 1,0,32'hCAFEF00D, 32'h90, 5'd4, 0};
    run_vec(v, "t9");
    chk("t9.err_to", 32'(err_timeout), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
